// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the read arbiter state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

endpackage

// File: rtl/axi_lite_read_arbiter_if.sv
// Bus bundle for the AXI-Lite read arbiter: NUM_REQ requester ports (s_*) and one downstream port (m_*).
// Every channel transfers on the rising aclk edge where valid && ready; a source holds valid and payload until then.
interface axi_lite_read_arbiter_if #(
  parameter int NUM_REQ      = 2,
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
);
  logic [NUM_REQ*ADDRESS_SIZE-1:0] s_araddr;
  logic [NUM_REQ-1:0]              s_arvalid;
  logic [NUM_REQ-1:0]              s_arready;
  logic [DATA_SIZE-1:0]            s_rdata;
  logic [1:0]                      s_rresp;
  logic [NUM_REQ-1:0]              s_rvalid;
  logic [NUM_REQ-1:0]              s_rready;
  logic [ADDRESS_SIZE-1:0]         m_araddr;
  logic                            m_arvalid;
  logic                            m_arready;
  logic [DATA_SIZE-1:0]            m_rdata;
  logic [1:0]                      m_rresp;
  logic                            m_rvalid;
  logic                            m_rready;

  modport slave (
    input  s_araddr, s_arvalid, s_rready, m_arready, m_rdata, m_rresp, m_rvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid, m_araddr, m_arvalid, m_rready
  );

  modport master (
    output s_araddr, s_arvalid, s_rready, m_arready, m_rdata, m_rresp, m_rvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid, m_araddr, m_arvalid, m_rready
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_req_o
);

  // Offsets are scanned from farthest to nearest so the nearest match is the last one written.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_req_o = |req_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_i[j] && ((int'(ptr_i) + k == j) || (int'(ptr_i) + k == j + NUM_REQ))) begin
          gnt_oh_o    = '0;
          gnt_oh_o[j] = 1'b1;
          gnt_idx_o   = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// Round-robin share of one AXI-Lite read subordinate among NUM_REQ requesters, one transaction in flight.
module axi_lite_read_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi_lite_read_arbiter_if.slave bus,
  output logic [2:0]            dbg_state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [2:0]              state_q,     state_d;
  logic [IDX_W-1:0]        ptr_q,       ptr_d;
  logic [IDX_W-1:0]        grant_q,     grant_d;
  logic [NUM_REQ-1:0]      s_arready_q, s_arready_d;
  logic [NUM_REQ-1:0]      s_rvalid_q,  s_rvalid_d;
  logic [DATA_SIZE-1:0]    s_rdata_q,   s_rdata_d;
  logic [1:0]              s_rresp_q,   s_rresp_d;
  logic [ADDRESS_SIZE-1:0] m_araddr_q,  m_araddr_d;
  logic                    m_arvalid_q, m_arvalid_d;
  logic                    m_rready_q,  m_rready_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i     (bus.s_arvalid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .any_req_o (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    s_arready_d = s_arready_q;
    s_rvalid_d  = s_rvalid_q;
    s_rdata_d   = s_rdata_q;
    s_rresp_d   = s_rresp_q;
    m_araddr_d  = m_araddr_q;
    m_arvalid_d = m_arvalid_q;
    m_rready_d  = m_rready_q;
    case (state_q)
      ST_IDLE: begin
        // s_arready is registered, so it is raised on the way into ACCEPT.
        if (arb_any) begin
          grant_d     = arb_idx;
          s_arready_d = arb_oh;
          state_d     = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        s_arready_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == IDX_W'(i)) m_araddr_d = bus.s_araddr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
        end
        m_arvalid_d = 1'b1;
        state_d     = ST_ADDR;
      end
      ST_ADDR: begin
        if (bus.m_arready) begin
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.m_rvalid) begin
          s_rdata_d  = bus.m_rdata;
          s_rresp_d  = bus.m_rresp;
          m_rready_d = 1'b0;
          for (int i = 0; i < NUM_REQ; i++) s_rvalid_d[i] = (grant_q == IDX_W'(i));
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // s_rvalid_q is one-hot on the grant, so this ignores other requesters' rready.
        if (|(bus.s_rready & s_rvalid_q)) begin
          s_rvalid_d = '0;
          ptr_d      = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      s_arready_q <= '0;
      s_rvalid_q  <= '0;
      s_rdata_q   <= '0;
      s_rresp_q   <= '0;
      m_araddr_q  <= '0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      s_arready_q <= s_arready_d;
      s_rvalid_q  <= s_rvalid_d;
      s_rdata_q   <= s_rdata_d;
      s_rresp_q   <= s_rresp_d;
      m_araddr_q  <= m_araddr_d;
      m_arvalid_q <= m_arvalid_d;
      m_rready_q  <= m_rready_d;
    end
  end

  assign bus.s_arready = s_arready_q;
  assign bus.s_rvalid  = s_rvalid_q;
  assign bus.s_rdata   = s_rdata_q;
  assign bus.s_rresp   = s_rresp_q;
  assign bus.m_araddr  = m_araddr_q;
  assign bus.m_arvalid = m_arvalid_q;
  assign bus.m_rready  = m_rready_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Directed bench for axi_lite_read_arbiter with three requesters and a cycle-by-cycle protocol/arbitration model.
module tb_axi_lite_read_arbiter;
  import axi_lite_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [2:0] dbg_state;
  int         cyc = 0;

  axi_lite_read_arbiter_if #(.NUM_REQ(N), .ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

  axi_lite_read_arbiter #(.NUM_REQ(N), .ADDRESS_SIZE(AW), .DATA_SIZE(DW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else passes++;
  endtask

  // ---------------- downstream subordinate driver ----------------
  int            dn_ar_wait = 0;
  int            dn_r_wait  = 0;
  logic [DW-1:0] dn_data    = '0;
  logic [1:0]    dn_resp    = RESP_OKAY;
  logic [DW+1:0] exp_q[$];

  initial begin
    int ph, cnt;
    ph = 0; cnt = 0;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_rresp = '0;
    forever begin
      @(posedge aclk); #2;
      bus.m_arready = 1'b0;
      bus.m_rvalid  = 1'b0;
      if (!aresetn) begin
        ph = 0;
      end else begin
        if (ph == 0 && bus.m_arvalid) begin cnt = dn_ar_wait; ph = 1; end
        if (ph == 1) begin
          if (cnt == 0) begin bus.m_arready = 1'b1; ph = 2; end
          else cnt--;
        end else if (ph == 2 && bus.m_rready) begin
          cnt = dn_r_wait; ph = 3;
        end
        if (ph == 3) begin
          if (cnt == 0) begin
            bus.m_rvalid = 1'b1; bus.m_rdata = dn_data; bus.m_rresp = dn_resp;
            exp_q.push_back({dn_data, dn_resp});
            ph = 0;
          end else cnt--;
        end
      end
    end
  end

  // ---------------- model + compare (every negedge) ----------------
  int            glog[$];
  logic [AW-1:0] alog[$];
  int            resp_cnt = 0;
  logic [DW-1:0] last_data;
  logic [1:0]    last_resp;
  int            t_ar, t_mar, t_mrr, t_srv;
  int            mav_len, mrr_len, srv_len;

  initial begin
    int mptr, cur_g, e;
    logic [AW-1:0] exp_addr;
    logic [N-1:0]  ev, p_arvalid, p_sar, p_srv, p_srr;
    logic          p_mav, p_mar, p_mrr, p_mrv;
    logic [DW-1:0] p_sdata;
    mptr = 0; cur_g = -1; exp_addr = '0;
    p_arvalid = '0; p_sar = '0; p_srv = '0; p_srr = '0;
    p_mav = 0; p_mar = 0; p_mrr = 0; p_mrv = 0; p_sdata = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        mptr = 0; cur_g = -1; exp_q.delete();
        p_arvalid = '0; p_sar = '0; p_srv = '0; p_srr = '0;
        p_mav = 0; p_mar = 0; p_mrr = 0; p_mrv = 0; p_sdata = '0;
      end else begin
        if (p_sar != 0) chk("arready_pulse", bus.s_arready, 0);
        if (bus.s_arready != 0) begin
          e = -1;
          for (int k = 0; k < N; k++) if (e < 0 && p_arvalid[(mptr + k) % N]) e = (mptr + k) % N;
          ev = '0;
          if (e >= 0) ev[e] = 1'b1;
          chk("grant", bus.s_arready, ev);
          chk("arready_without_arvalid", bus.s_arready & ~bus.s_arvalid, 0);
          if (e >= 0) begin
            cur_g = e; exp_addr = bus.s_araddr[e*AW +: AW];
          end
          glog.push_back(e); t_ar = cyc;
        end
        if (bus.m_arvalid) begin
          chk("m_araddr", bus.m_araddr, exp_addr);
          if (!p_mav) begin t_mar = cyc; mav_len = 0; end
          mav_len++;
          if (bus.m_arready) alog.push_back(bus.m_araddr);
        end
        if (p_mav && !p_mar) chk("m_arvalid_hold", bus.m_arvalid, 1);
        if (p_mav && p_mar)  chk("m_rready_after_ar", bus.m_rready, 1);
        if (bus.m_rready) begin
          if (!p_mrr) begin t_mrr = cyc; mrr_len = 0; end
          mrr_len++;
        end
        if (p_mrr && !p_mrv) chk("m_rready_hold", bus.m_rready, 1);
        if (p_srv != 0 && (p_srv & p_srr) == 0) begin
          chk("s_rvalid_hold", bus.s_rvalid, p_srv);
          chk("s_rdata_hold", bus.s_rdata, p_sdata);
        end
        if (bus.s_rvalid != 0) begin
          ev = '0;
          if (cur_g >= 0) ev[cur_g] = 1'b1;
          chk("s_rvalid", bus.s_rvalid, ev);
          if (exp_q.size() == 0) chk("s_rvalid_unexpected", 1, 0);
          else begin
            chk("s_rdata", bus.s_rdata, exp_q[0][DW+1:2]);
            chk("s_rresp", bus.s_rresp, exp_q[0][1:0]);
          end
          if (p_srv == 0) begin t_srv = cyc; srv_len = 0; end
          srv_len++;
          if ((bus.s_rvalid & bus.s_rready) != 0) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            last_data = bus.s_rdata; last_resp = bus.s_rresp;
            resp_cnt++;
            if (cur_g >= 0) mptr = (cur_g + 1) % N;
            cur_g = -1;
          end
        end
        p_arvalid = bus.s_arvalid; p_sar = bus.s_arready;
        p_mav = bus.m_arvalid; p_mar = bus.m_arready;
        p_mrr = bus.m_rready;  p_mrv = bus.m_rvalid;
        p_srv = bus.s_rvalid;  p_srr = bus.s_rready; p_sdata = bus.s_rdata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_addr(input int idx, input logic [AW-1:0] a);
    bus.s_araddr[idx*AW +: AW] = a;
  endtask

  task automatic do_reset();
    @(posedge aclk); #1 aresetn = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
  endtask

  // Waits for any accept, then drops that requester's arvalid after the handshake edge.
  task automatic accept_any();
    for (int t = 0; t < 100; t++) begin
      @(negedge aclk);
      if (bus.s_arready != 0) begin
        logic [N-1:0] sel;
        sel = bus.s_arready;
        @(posedge aclk); #1;
        bus.s_arvalid = bus.s_arvalid & ~sel;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    bus.s_arvalid = '0;
  endtask

  task automatic wait_resps(input int target);
    for (int t = 0; t < 300; t++) begin
      @(negedge aclk); #1;
      if (resp_cnt >= target) return;
    end
    chk("response_timeout", resp_cnt, target);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c0, base, n_acc, guard;
    logic [N-1:0] sel;
    bus.s_arvalid = '0; bus.s_araddr = '0; bus.s_rready = '1;

    // reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_arready", bus.s_arready, 0);
    chk("rst_s_rvalid", bus.s_rvalid, 0);
    chk("rst_s_rdata", bus.s_rdata, 0);
    chk("rst_s_rresp", bus.s_rresp, 0);
    chk("rst_m_araddr", bus.m_araddr, 0);
    chk("rst_m_arvalid", bus.m_arvalid, 0);
    chk("rst_m_rready", bus.m_rready, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    @(posedge aclk); #1 aresetn = 1'b1;

    // single request, zero wait states
    repeat (2) @(posedge aclk);
    #1;
    dn_data = 32'hDEAD_BEEF; dn_resp = RESP_OKAY;
    set_addr(0, 32'h0000_0010);
    c0 = cyc; base = resp_cnt;
    bus.s_arvalid[0] = 1'b1;
    accept_any();
    wait_resps(base + 1);
    chk("single_grant", glog[glog.size()-1], 0);
    chk("lat_s_arready", t_ar - c0, 1);
    chk("lat_m_arvalid", t_mar - c0, 2);
    chk("lat_m_rready", t_mrr - c0, 3);
    chk("lat_s_rvalid", t_srv - c0, 4);
    chk("single_rdata", last_data, 32'hDEAD_BEEF);
    chk("single_rresp", last_resp, 2'b00);
    chk("single_m_araddr", alog[alog.size()-1], 32'h10);

    // fairness: 0 and 1 requesting continuously
    do_reset();
    glog.delete(); alog.delete();
    dn_data = 32'h5555_0000;
    set_addr(0, 32'h100); set_addr(1, 32'h200);
    base = resp_cnt; n_acc = 0; guard = 0;
    bus.s_arvalid = 3'b011;
    while (bus.s_arvalid != 0 && guard < 400) begin
      @(negedge aclk);
      guard++;
      if (bus.s_arready != 0) begin
        n_acc++;
        if (n_acc >= 6) begin
          sel = bus.s_arready;
          @(posedge aclk); #1;
          bus.s_arvalid = bus.s_arvalid & ~sel;
        end
      end
    end
    if (guard >= 400) begin chk("fair_timeout", 0, 1); bus.s_arvalid = '0; end
    wait_resps(base + 7);
    if (glog.size() >= 7) begin
      for (int i = 0; i < 6; i++) chk("fair_grant", glog[i], i % 2);
      chk("fair_grant7", glog[6], 0);
    end else chk("fair_count", glog.size(), 7);
    if (alog.size() >= 6)
      for (int i = 0; i < 6; i++) chk("fair_m_araddr", alog[i], (i % 2 == 1) ? 32'h200 : 32'h100);

    // backpressure on every channel (pointer now 1)
    dn_ar_wait = 3; dn_r_wait = 5; dn_data = 32'h1234_5678;
    set_addr(1, 32'h300);
    base = resp_cnt;
    bus.s_rready[1] = 1'b0;
    bus.s_arvalid[1] = 1'b1;
    accept_any();
    for (int t = 0; t < 100; t++) begin
      @(negedge aclk);
      if (bus.s_rvalid[1]) break;
    end
    repeat (4) @(posedge aclk);
    #1 bus.s_rready[1] = 1'b1;
    wait_resps(base + 1);
    chk("bp_grant", glog[glog.size()-1], 1);
    chk("bp_m_arvalid_cycles", mav_len, 4);
    chk("bp_m_rready_cycles", mrr_len, 6);
    chk("bp_s_rvalid_cycles", srv_len, 5);
    chk("bp_rdata", last_data, 32'h1234_5678);
    dn_ar_wait = 0; dn_r_wait = 0;

    // SLVERR pass-through to requester 1, requester 0 arrives late
    dn_data = 32'h0; dn_resp = RESP_SLVERR;
    set_addr(1, 32'h400); set_addr(0, 32'h500);
    base = resp_cnt;
    bus.s_arvalid[1] = 1'b1;
    accept_any();
    bus.s_arvalid[0] = 1'b1;
    wait_resps(base + 1);
    chk("err_grant", glog[glog.size()-1], 1);
    chk("err_rresp", last_resp, 2'b10);
    chk("err_rdata", last_data, 32'h0);
    dn_resp = RESP_OKAY; dn_data = 32'hCAFE_0000;
    accept_any();
    wait_resps(base + 2);
    chk("err_next_grant", glog[glog.size()-1], 0);
    chk("err_next_addr", alog[alog.size()-1], 32'h500);

    // wrap-around: serve 2 from pointer 0, then 0 and 1 pending
    do_reset();
    set_addr(2, 32'h600); set_addr(0, 32'h700); set_addr(1, 32'h800);
    base = resp_cnt;
    bus.s_arvalid[2] = 1'b1;
    accept_any();
    bus.s_arvalid[0] = 1'b1; bus.s_arvalid[1] = 1'b1;
    accept_any();
    accept_any();
    wait_resps(base + 3);
    chk("wrap_g0", glog[glog.size()-3], 2);
    chk("wrap_g1", glog[glog.size()-2], 0);
    chk("wrap_g2", glog[glog.size()-1], 1);

    // reset while waiting for downstream data (pointer now 2)
    dn_r_wait = 8; dn_data = 32'hBAD0_BAD0;
    set_addr(2, 32'h900);
    bus.s_arvalid[2] = 1'b1;
    accept_any();
    for (int t = 0; t < 50; t++) begin
      @(negedge aclk);
      if (bus.m_rready) break;
    end
    chk("mid_in_data", dbg_state, ST_DATA);
    do_reset();
    @(negedge aclk);
    chk("mid_s_rvalid", bus.s_rvalid, 0);
    chk("mid_m_rready", bus.m_rready, 0);
    chk("mid_m_arvalid", bus.m_arvalid, 0);
    chk("mid_m_araddr", bus.m_araddr, 0);
    chk("mid_s_arready", bus.s_arready, 0);
    chk("mid_state", dbg_state, ST_IDLE);
    dn_r_wait = 0; dn_data = 32'hFEED_0001;
    set_addr(0, 32'hA00); set_addr(2, 32'hB00);
    base = resp_cnt;
    @(posedge aclk); #1;
    bus.s_arvalid = 3'b101;
    accept_any();
    accept_any();
    wait_resps(base + 2);
    chk("post_rst_g0", glog[glog.size()-2], 0);
    chk("post_rst_g1", glog[glog.size()-1], 2);
    chk("post_rst_rdata", last_data, 32'hFEED_0001);

    repeat (3) @(posedge aclk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (time %0t)", $time);
    checks++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
